// File: rtl/stage3_bist_if.sv
// Operand/result bus between the BIST sequencer and stage3Integration.
// The master drives ALU operands and controls; the slave returns the registered result.
interface stage3_bist_if;
  logic [15:0] ALUInA;
  logic [15:0] ALUInB;
  logic [3:0]  ALUop;
  logic        ResSource;
  logic        ResWrite;
  logic [15:0] ResOut;

  modport master (
    output ALUInA, ALUInB, ALUop, ResSource, ResWrite,
    input  ResOut
  );

  modport slave (
    input  ALUInA, ALUInB, ALUop, ResSource, ResWrite,
    output ResOut
  );
endinterface

// File: rtl/stage3_bist.sv
// Built-in self test for stage3Integration: sweeps AND/OR/ADD/SUB/SLT with generated
// operands, compares the registered result one cycle later and reports error statistics.
module stage3_bist #(
  parameter int VECTORS     = 100,
  parameter int WARMUP      = 4,
  parameter int STOP_ON_ERR = 0
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  stage3_bist_if.master bus,
  output logic        Busy,
  output logic        Done,
  output logic        Pass,
  output logic [15:0] ErrCount,
  output logic [15:0] TrialCount,
  output logic [15:0] FailIndex,
  output logic [3:0]  FailOp
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WARMUP = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } stateT;

  localparam logic [3:0]  OP_AND   = 4'd0;
  localparam logic [3:0]  OP_OR    = 4'd1;
  localparam logic [3:0]  OP_ADD   = 4'd2;
  localparam logic [3:0]  OP_SUB   = 4'd6;
  localparam logic [3:0]  OP_SLT   = 4'd4;
  localparam logic [2:0]  LAST_OP  = 3'd4;
  localparam logic [15:0] LAST_VEC = 16'(VECTORS - 1);
  // A zero WARMUP still spends one settling cycle before the first vector.
  localparam logic [15:0] WARM_LAST = (WARMUP > 0) ? 16'(WARMUP - 1) : 16'd0;

  function automatic logic [3:0] opAt(input logic [2:0] ptr);
    logic [3:0] op;
    case (ptr)
      3'd0:    op = OP_AND;
      3'd1:    op = OP_OR;
      3'd2:    op = OP_ADD;
      3'd3:    op = OP_SUB;
      3'd4:    op = OP_SLT;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  function automatic logic [15:0] stimA(input logic [15:0] idx);
    return idx * 16'd5;
  endfunction

  function automatic logic [15:0] stimB(input logic [15:0] idx);
    return 16'hFFFF - (idx * 16'd3);
  endfunction

  function automatic logic [15:0] aluRef(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLT:  r = (a < b) ? 16'd1 : 16'd0;
      default: r = 16'd0;
    endcase
    return r;
  endfunction

  stateT       state_r, stateNext_s;
  logic [15:0] warmCnt_r, warmCnt_s;
  logic [15:0] vecIdx_r, vecIdx_s;
  logic [15:0] perOp_r, perOp_s;
  logic [2:0]  opPtr_r, opPtr_s;
  logic [15:0] aluInA_r, aluInA_s;
  logic [15:0] aluInB_r, aluInB_s;
  logic [3:0]  aluOp_r, aluOp_s;
  logic        resWrite_r, resWrite_s;
  logic [15:0] expRes_r, expRes_s;
  logic [15:0] expIdx_r, expIdx_s;
  logic [3:0]  expOp_r, expOp_s;
  logic        cmpValid_r, cmpValid_s;
  logic [15:0] errCount_r, errCount_s;
  logic [15:0] trialCount_r, trialCount_s;
  logic [15:0] failIndex_r, failIndex_s;
  logic [3:0]  failOp_r, failOp_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        pass_r, pass_s;
  logic        cmpNow_s;
  logic        mismatch_s;

  // Next-state, vector sequencing, compare bookkeeping and next registered outputs.
  always_comb begin
    stateNext_s  = state_r;
    warmCnt_s    = warmCnt_r;
    vecIdx_s     = vecIdx_r;
    perOp_s      = perOp_r;
    opPtr_s      = opPtr_r;
    expRes_s     = expRes_r;
    expIdx_s     = expIdx_r;
    expOp_s      = expOp_r;
    cmpValid_s   = cmpValid_r;
    errCount_s   = errCount_r;
    trialCount_s = trialCount_r;
    failIndex_s  = failIndex_r;
    failOp_s     = failOp_r;
    aluInA_s     = 16'd0;
    aluInB_s     = 16'd0;
    aluOp_s      = 4'd0;
    resWrite_s   = 1'b0;
    busy_s       = 1'b0;
    done_s       = 1'b0;
    pass_s       = 1'b0;

    cmpNow_s   = cmpValid_r && ((state_r == ST_RUN) || (state_r == ST_DRAIN));
    mismatch_s = cmpNow_s && (bus.ResOut != expRes_r);

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          stateNext_s  = ST_WARMUP;
          warmCnt_s    = 16'd0;
          vecIdx_s     = 16'd0;
          perOp_s      = 16'd0;
          opPtr_s      = 3'd0;
          cmpValid_s   = 1'b0;
          errCount_s   = 16'd0;
          trialCount_s = 16'd0;
          failIndex_s  = 16'd0;
          failOp_s     = 4'd0;
        end else begin
          stateNext_s = state_r;
        end
      end
      ST_WARMUP: begin
        if (warmCnt_r >= WARM_LAST) begin
          stateNext_s = ST_RUN;
          vecIdx_s    = 16'd0;
          perOp_s     = 16'd0;
          opPtr_s     = 3'd0;
        end else begin
          warmCnt_s = warmCnt_r + 16'd1;
        end
      end
      ST_RUN: begin
        // The vector on the bus now is answered by ResOut one cycle later.
        expRes_s   = aluRef(aluOp_r, aluInA_r, aluInB_r);
        expIdx_s   = vecIdx_r;
        expOp_s    = aluOp_r;
        cmpValid_s = 1'b1;
        if (mismatch_s && (STOP_ON_ERR != 0)) begin
          stateNext_s = ST_DONE;
          cmpValid_s  = 1'b0;
        end else if ((opPtr_r == LAST_OP) && (perOp_r == LAST_VEC)) begin
          stateNext_s = ST_DRAIN;
        end else begin
          vecIdx_s = vecIdx_r + 16'd1;
          if (perOp_r == LAST_VEC) begin
            perOp_s = 16'd0;
            opPtr_s = opPtr_r + 3'd1;
          end else begin
            perOp_s = perOp_r + 16'd1;
          end
        end
      end
      ST_DRAIN: begin
        cmpValid_s  = 1'b0;
        stateNext_s = ST_DONE;
      end
      default: begin
        stateNext_s = ST_IDLE;
        cmpValid_s  = 1'b0;
      end
    endcase

    if (cmpNow_s) begin
      trialCount_s = trialCount_r + 16'd1;
      if (mismatch_s) begin
        if (errCount_r != 16'hFFFF) begin
          errCount_s = errCount_r + 16'd1;
        end else begin
          errCount_s = errCount_r;
        end
        if (errCount_r == 16'd0) begin
          failIndex_s = expIdx_r;
          failOp_s    = expOp_r;
        end else begin
          failIndex_s = failIndex_r;
        end
      end else begin
        errCount_s = errCount_r;
      end
    end else begin
      trialCount_s = trialCount_s;
    end

    case (stateNext_s)
      ST_RUN: begin
        aluInA_s   = stimA(vecIdx_s);
        aluInB_s   = stimB(vecIdx_s);
        aluOp_s    = opAt(opPtr_s);
        resWrite_s = 1'b1;
        busy_s     = 1'b1;
      end
      ST_WARMUP, ST_DRAIN: begin
        resWrite_s = 1'b1;
        busy_s     = 1'b1;
      end
      ST_DONE: begin
        done_s = 1'b1;
        pass_s = (errCount_s == 16'd0);
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // State, pipeline, statistics and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r      <= ST_IDLE;
      warmCnt_r    <= 16'd0;
      vecIdx_r     <= 16'd0;
      perOp_r      <= 16'd0;
      opPtr_r      <= 3'd0;
      aluInA_r     <= 16'd0;
      aluInB_r     <= 16'd0;
      aluOp_r      <= 4'd0;
      resWrite_r   <= 1'b0;
      expRes_r     <= 16'd0;
      expIdx_r     <= 16'd0;
      expOp_r      <= 4'd0;
      cmpValid_r   <= 1'b0;
      errCount_r   <= 16'd0;
      trialCount_r <= 16'd0;
      failIndex_r  <= 16'd0;
      failOp_r     <= 4'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
    end else begin
      state_r      <= stateNext_s;
      warmCnt_r    <= warmCnt_s;
      vecIdx_r     <= vecIdx_s;
      perOp_r      <= perOp_s;
      opPtr_r      <= opPtr_s;
      aluInA_r     <= aluInA_s;
      aluInB_r     <= aluInB_s;
      aluOp_r      <= aluOp_s;
      resWrite_r   <= resWrite_s;
      expRes_r     <= expRes_s;
      expIdx_r     <= expIdx_s;
      expOp_r      <= expOp_s;
      cmpValid_r   <= cmpValid_s;
      errCount_r   <= errCount_s;
      trialCount_r <= trialCount_s;
      failIndex_r  <= failIndex_s;
      failOp_r     <= failOp_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      pass_r       <= pass_s;
    end
  end

  assign bus.ALUInA    = aluInA_r;
  assign bus.ALUInB    = aluInB_r;
  assign bus.ALUop     = aluOp_r;
  assign bus.ResSource = 1'b0;
  assign bus.ResWrite  = resWrite_r;
  assign Busy          = busy_r;
  assign Done          = done_r;
  assign Pass          = pass_r;
  assign ErrCount      = errCount_r;
  assign TrialCount    = trialCount_r;
  assign FailIndex     = failIndex_r;
  assign FailOp        = failOp_r;

endmodule

// File: tb/tb_stage3_bist.sv
// Directed bench for stage3_bist: a behavioural stage3Integration answers each BIST,
// with an optional bit0 stuck-at-1 fault; expected values are hand-computed.
module tb_stage3_bist;
  localparam int W    = 4;
  localparam int V    = 100;
  localparam int NLOG = 600;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst0, start0, fault0, rst1, start1, fault1;
  logic busy0, done0, pass0, busy1, done1, pass1;
  logic [15:0] err0, trial0, fidx0, err1, trial1, fidx1;
  logic [3:0]  fop0, fop1;

  stage3_bist_if bus0();
  stage3_bist_if bus1();

  stage3_bist #(.VECTORS(V), .WARMUP(W), .STOP_ON_ERR(0)) dut0 (
    .CLK(CLK), .Reset(rst0), .Start(start0), .bus(bus0),
    .Busy(busy0), .Done(done0), .Pass(pass0), .ErrCount(err0),
    .TrialCount(trial0), .FailIndex(fidx0), .FailOp(fop0)
  );

  stage3_bist #(.VECTORS(V), .WARMUP(W), .STOP_ON_ERR(1)) dut1 (
    .CLK(CLK), .Reset(rst1), .Start(start1), .bus(bus1),
    .Busy(busy1), .Done(done1), .Pass(pass1), .ErrCount(err1),
    .TrialCount(trial1), .FailIndex(fidx1), .FailOp(fop1)
  );

  function automatic logic [15:0] goldAlu(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd4:    return (a < b) ? 16'd1 : 16'd0;
      default: return 16'd0;
    endcase
  endfunction

  // Behavioural stage3Integration result registers.
  always @(posedge CLK) begin
    if (rst0) bus0.ResOut <= 16'd0;
    else if (bus0.ResWrite) bus0.ResOut <= goldAlu(bus0.ALUop, bus0.ALUInA, bus0.ALUInB) | {15'd0, fault0};
    if (rst1) bus1.ResOut <= 16'd0;
    else if (bus1.ResWrite) bus1.ResOut <= goldAlu(bus1.ALUop, bus1.ALUInA, bus1.ALUInB) | {15'd0, fault1};
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  logic [15:0] lgA[NLOG], lgB[NLOG], lgRes[NLOG], lgTrial[NLOG];
  logic [3:0]  lgOp[NLOG];
  logic        lgBusy[NLOG], lgRw[NLOG], lgDone[NLOG], lgZero[NLOG];

  function automatic logic allZero0();
    return ({bus0.ALUInA, bus0.ALUInB, bus0.ALUop, bus0.ResSource, bus0.ResWrite, busy0,
             done0, pass0, err0, trial0, fidx0, fop0} == '0);
  endfunction

  task automatic capture0(input int n);
    lgA[n] = bus0.ALUInA;  lgB[n] = bus0.ALUInB;  lgOp[n] = bus0.ALUop;
    lgRes[n] = bus0.ResOut; lgTrial[n] = trial0;  lgBusy[n] = busy0;
    lgRw[n] = bus0.ResWrite; lgDone[n] = done0;   lgZero[n] = allZero0();
  endtask

  // Start sampled at edge 0; Start/Reset can also be pulsed so they are sampled at a given edge.
  task automatic runSeq0(input int maxEdge, input int startAt, input int rstAt, output int doneEdge);
    doneEdge = -1;
    @(negedge CLK); start0 = 1'b1;
    @(posedge CLK); #1; capture0(0);
    for (int n = 1; n <= maxEdge; n++) begin
      @(negedge CLK);
      start0 = (n == startAt);
      rst0   = (n == rstAt);
      @(posedge CLK); #1;
      capture0(n);
      if (done0 && doneEdge < 0) doneEdge = n;
    end
    @(negedge CLK); start0 = 1'b0; rst0 = 1'b0;
  endtask

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [15:0] res;
  } vecT;

  vecT tbl[8];
  int  de;

  initial begin
    tbl[0] = '{0,   16'h0000, 16'hFFFF, 4'd0, 16'h0000};
    tbl[1] = '{1,   16'h0005, 16'hFFFC, 4'd0, 16'h0004};
    tbl[2] = '{99,  16'h01EF, 16'hFED6, 4'd0, 16'h00C6};
    tbl[3] = '{100, 16'h01F4, 16'hFED3, 4'd1, 16'hFFF7};
    tbl[4] = '{200, 16'h03E8, 16'hFDA7, 4'd2, 16'h018F};
    tbl[5] = '{300, 16'h05DC, 16'hFC7B, 4'd6, 16'h0961};
    tbl[6] = '{400, 16'h07D0, 16'hFB4F, 4'd4, 16'h0001};
    tbl[7] = '{499, 16'h09BF, 16'hFA26, 4'd4, 16'h0001};

    rst0 = 1'b1; start0 = 1'b0; fault0 = 1'b0;
    rst1 = 1'b1; start1 = 1'b0; fault1 = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_zero0", 128'(allZero0()), 128'd1);
    chk("reset_zero1", {bus1.ALUop, bus1.ResWrite, busy1, done1, pass1, err1, trial1, fidx1, fop1},
        128'd0);
    @(negedge CLK); rst0 = 1'b0; rst1 = 1'b0;
    @(posedge CLK); #1;
    chk("idle_quiet", {busy0, done0, bus0.ResWrite, bus0.ResSource}, 128'd0);

    // Golden run with a Start pulse mid-RUN that must be ignored.
    runSeq0(520, 250, -1, de);
    chk("golden_done_edge", 128'(de), 128'd505);
    chk("golden_not_early", 128'(lgDone[504]), 128'd0);
    for (int n = 0; n < W; n++)
      chk("warmup_bus", {lgA[n], lgB[n], lgOp[n], lgBusy[n], lgRw[n]}, {16'h0, 16'h0, 4'h0, 1'b1, 1'b1});
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("vec_drive_i%0d", tbl[k].idx),
          {lgA[W + tbl[k].idx], lgB[W + tbl[k].idx], lgOp[W + tbl[k].idx]},
          {tbl[k].a, tbl[k].b, tbl[k].op});
      chk($sformatf("vec_res_i%0d", tbl[k].idx), lgRes[W + tbl[k].idx + 1], tbl[k].res);
    end
    chk("drain_busy", {lgBusy[504], lgRw[504], lgDone[504]}, {1'b1, 1'b1, 1'b0});
    chk("golden_trial_at_done", lgTrial[505], 128'd500);
    chk("done_outputs", {lgBusy[510], lgRw[510]}, 128'd0);
    chk("golden_hold", {pass0, err0, trial0, fidx0, fop0, done0},
        {1'b1, 16'd0, 16'd500, 16'd0, 4'd0, 1'b1});

    // Rerun from DONE, then Reset while vector i=150 is on the bus.
    runSeq0(170, -1, W + 151, de);
    chk("rerun_clear", lgTrial[0], 128'd0);
    chk("rerun_vec0", {lgA[W], lgB[W], lgOp[W]}, {16'h0000, 16'hFFFF, 4'd0});
    chk("i150_bus", {lgA[W + 150], lgOp[W + 150]}, {16'h02EE, 4'd1});
    chk("i150_trial", lgTrial[W + 150], 128'd149);
    chk("midrun_reset_zero", 128'(lgZero[W + 151]), 128'd1);
    chk("reset_stays_idle", 128'(lgZero[170]), 128'd1);
    chk("reset_no_done", 128'(de), 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);

    // bit0 stuck-at-1: only AND vectors (expected bit0 always 0) mismatch.
    fault0 = 1'b1;
    runSeq0(520, -1, -1, de);
    chk("fault_done_edge", 128'(de), 128'd505);
    chk("fault_stats", {pass0, err0, trial0, fidx0, fop0},
        {1'b0, 16'd100, 16'd500, 16'd0, 4'd0});

    // Same fault with STOP_ON_ERR=1: stops at the first compare.
    de = -1;
    @(negedge CLK); start1 = 1'b1;
    @(posedge CLK); #1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK); start1 = 1'b0;
      @(posedge CLK); #1;
      if (done1 && de < 0) de = n;
    end
    chk("stop_done_edge", 128'(de), 128'(W + 2));
    chk("stop_stats", {pass1, err1, trial1, fidx1, fop1, bus1.ResWrite, busy1},
        {1'b0, 16'd1, 16'd1, 16'd0, 4'd0, 1'b0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
